// File: rtl/alu_pkg.sv
// alu_pkg: source tags and result-entry type shared by the ALU output stage and decoder
package alu_pkg;
   localparam logic [1:0] SRC_ARITH = 2'b00;
   localparam logic [1:0] SRC_LOGIC = 2'b01;
   localparam logic [1:0] SRC_CMP   = 2'b10;
   localparam logic [1:0] SRC_SHIFT = 2'b11;
   localparam int ALU_DATA_WIDTH = 16;
   typedef struct packed {
      logic [1:0]                tag;
      logic [ALU_DATA_WIDTH-1:0] data;
   } alu_entry_t;
endpackage

// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if: unit results in, tagged result stream and status out
interface alu_result_collector_if #(
   parameter int OUT_DATA_WIDTH = 16,
   parameter int DEPTH          = 4,
   parameter int CNT_WIDTH      = $clog2(DEPTH + 1)
);
   logic [OUT_DATA_WIDTH-1:0] Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT;
   logic                      Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
   logic                      OUT_Ready;
   logic                      Err_Clear;
   logic [OUT_DATA_WIDTH-1:0] OUT_Data;
   logic [1:0]                OUT_Src;
   logic                      OUT_Valid;
   logic [CNT_WIDTH-1:0]      OUT_Count;
   logic                      Full;
   logic                      Overflow;
   logic                      Collision;
   modport master (
      output Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
      output Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
      output OUT_Ready, Err_Clear,
      input  OUT_Data, OUT_Src, OUT_Valid, OUT_Count, Full, Overflow, Collision
   );
   modport slave (
      input  Arith_OUT, Logic_OUT, CMP_OUT, Shift_OUT,
      input  Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
      input  OUT_Ready, Err_Clear,
      output OUT_Data, OUT_Src, OUT_Valid, OUT_Count, Full, Overflow, Collision
   );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: generic first-word-fall-through FIFO with separate occupancy count
module alu_result_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [CW-1:0]    o_count
);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_wr, w_rd;
   assign o_empty = r_count == '0;
   assign o_full  = r_count == CW'(DEPTH);
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd_ptr];
   assign w_rd    = i_pop && !o_empty;
   // a full FIFO still takes a write when the head leaves in the same cycle
   assign w_wr    = i_push && (!o_full || w_rd);
   // storage is deliberately left unreset; only pointers and count define contents
   always_ff @(posedge CLK)
      if (w_wr) r_mem[r_wr_ptr] <= i_din;
   // pointers wrap naturally at DEPTH (power of two); count tracks occupancy 0..DEPTH
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_wr) - CW'(w_rd);
      end
endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: merges ALU unit results into one tagged, buffered valid/ready stream
module alu_result_collector
   import alu_pkg::*;
#(
   parameter int OUT_DATA_WIDTH = ALU_DATA_WIDTH,
   parameter int DEPTH          = 4,
   localparam int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
   input logic CLK,
   input logic RST,
   alu_result_collector_if.slave bus
);
   logic [3:0]           w_flags;
   logic                 w_push, w_pop, w_full, w_empty, w_collide, w_drop;
   alu_entry_t           w_sel, w_head;
   logic [CNT_WIDTH-1:0] w_count;
   logic                 r_overflow, r_collision;
   assign w_flags   = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
   assign w_push    = |w_flags;
   assign w_collide = (w_flags & (w_flags - 4'd1)) != 4'd0;
   assign w_pop     = !w_empty && bus.OUT_Ready;
   assign w_drop    = w_push && w_full && !w_pop;
   // fixed priority Arith > Logic > CMP > Shift; lower-priority results are discarded
   always_comb
      w_sel = bus.Arith_Flag ? alu_entry_t'({SRC_ARITH, bus.Arith_OUT}) :
              bus.Logic_Flag ? alu_entry_t'({SRC_LOGIC, bus.Logic_OUT}) :
              bus.CMP_Flag   ? alu_entry_t'({SRC_CMP,   bus.CMP_OUT})   :
                               alu_entry_t'({SRC_SHIFT, bus.Shift_OUT});
   alu_result_fifo #(.WIDTH($bits(alu_entry_t)), .DEPTH(DEPTH)) u_fifo (
      .CLK     (CLK),
      .RST     (RST),
      .i_push  (w_push),
      .i_din   (w_sel),
      .i_pop   (w_pop),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );
   // sticky error flags; a new error in the clearing cycle keeps the flag set
   always_ff @(posedge CLK or negedge RST)
      if (!RST) begin
         r_overflow  <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_overflow  <= w_drop || (r_overflow && !bus.Err_Clear);
         r_collision <= w_collide || (r_collision && !bus.Err_Clear);
      end
   assign bus.OUT_Valid = !w_empty;
   assign bus.OUT_Data  = w_empty ? '0 : w_head.data;
   assign bus.OUT_Src   = w_empty ? '0 : w_head.tag;
   assign bus.OUT_Count = w_count;
   assign bus.Full      = w_full;
   assign bus.Overflow  = r_overflow;
   assign bus.Collision = r_collision;
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: directed scoreboard bench for the ALU result collector
module tb_alu_result_collector;
   import alu_pkg::*;
   localparam int W  = 16;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);
   logic CLK = 1'b0;
   logic RST;
   int checks = 0;
   int errors = 0;
   logic [W+1:0] sb[$];
   alu_result_collector_if #(.OUT_DATA_WIDTH(W), .DEPTH(D)) bus ();
   alu_result_collector #(.OUT_DATA_WIDTH(W), .DEPTH(D)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));
   always #5 CLK = ~CLK;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // advance one clock; a handshake at this edge pops and checks the scoreboard head
   task automatic step();
      if (bus.OUT_Valid && bus.OUT_Ready) begin
         chk("pop_expected", sb.size() != 0, 1);
         if (sb.size() != 0) chk("pop_entry", {bus.OUT_Src, bus.OUT_Data}, sb.pop_front());
      end
      @(posedge CLK);
      #1;
   endtask
   task automatic clear_flags();
      bus.Arith_Flag = 0; bus.Logic_Flag = 0; bus.CMP_Flag = 0; bus.Shift_Flag = 0;
   endtask
   // one single-unit push for one cycle; accepted results go to the scoreboard
   task automatic push(input logic [1:0] src, input logic [W-1:0] d, input bit accept);
      case (src)
         SRC_ARITH: begin bus.Arith_Flag = 1; bus.Arith_OUT = d; end
         SRC_LOGIC: begin bus.Logic_Flag = 1; bus.Logic_OUT = d; end
         SRC_CMP:   begin bus.CMP_Flag   = 1; bus.CMP_OUT   = d; end
         default:   begin bus.Shift_Flag = 1; bus.Shift_OUT = d; end
      endcase
      if (accept) sb.push_back({src, d});
      step();
      clear_flags();
   endtask
   initial begin
      RST = 0;
      clear_flags();
      bus.Arith_OUT = 0; bus.Logic_OUT = 0; bus.CMP_OUT = 0; bus.Shift_OUT = 0;
      bus.OUT_Ready = 0; bus.Err_Clear = 0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_valid", bus.OUT_Valid, 0);
      chk("rst_data", bus.OUT_Data, 0);
      chk("rst_src", bus.OUT_Src, 0);
      chk("rst_count", bus.OUT_Count, 0);
      chk("rst_full", bus.Full, 0);
      chk("rst_ovf", bus.Overflow, 0);
      chk("rst_coll", bus.Collision, 0);
      RST = 1;
      step();
      push(SRC_SHIFT, 16'h00F0, 1);
      chk("t1_valid", bus.OUT_Valid, 1);
      chk("t1_data", bus.OUT_Data, 16'h00F0);
      chk("t1_src", bus.OUT_Src, 2'b11);
      chk("t1_count", bus.OUT_Count, 1);
      bus.OUT_Ready = 1;
      step();
      bus.OUT_Ready = 0;
      chk("t1_empty_valid", bus.OUT_Valid, 0);
      chk("t1_empty_data", bus.OUT_Data, 0);
      bus.Arith_Flag = 1; bus.Arith_OUT = 16'h0005;
      bus.Shift_Flag = 1; bus.Shift_OUT = 16'h0002;
      sb.push_back({SRC_ARITH, 16'h0005});
      step();
      clear_flags();
      chk("coll_set", bus.Collision, 1);
      chk("coll_count", bus.OUT_Count, 1);
      chk("coll_data", bus.OUT_Data, 16'h0005);
      chk("coll_src", bus.OUT_Src, 2'b00);
      bus.Err_Clear = 1;
      step();
      bus.Err_Clear = 0;
      chk("coll_clear", bus.Collision, 0);
      bus.OUT_Ready = 1;
      step();
      bus.OUT_Ready = 0;
      chk("coll_drained", bus.OUT_Count, 0);
      push(SRC_LOGIC, 16'h0011, 1);
      push(SRC_CMP,   16'h0022, 1);
      push(SRC_ARITH, 16'h0033, 1);
      chk("fill3_full", bus.Full, 0);
      push(SRC_SHIFT, 16'h0044, 1);
      chk("fill4_full", bus.Full, 1);
      chk("fill4_count", bus.OUT_Count, 4);
      chk("fill4_ovf", bus.Overflow, 0);
      push(SRC_LOGIC, 16'h0055, 0);
      chk("drop_ovf", bus.Overflow, 1);
      chk("drop_count", bus.OUT_Count, 4);
      chk("drop_head", bus.OUT_Data, 16'h0011);
      bus.Err_Clear = 1;
      push(SRC_CMP, 16'h0066, 0);
      chk("ovf_set_wins", bus.Overflow, 1);
      step();
      bus.Err_Clear = 0;
      chk("ovf_clear", bus.Overflow, 0);
      bus.OUT_Ready = 1;
      push(SRC_ARITH, 16'h1234, 1);
      chk("fullpp_ovf", bus.Overflow, 0);
      chk("fullpp_count", bus.OUT_Count, 4);
      repeat (4) step();
      bus.OUT_Ready = 0;
      chk("fullpp_drained", bus.OUT_Valid, 0);
      chk("fullpp_sb_empty", sb.size(), 0);
      bus.OUT_Ready = 1;
      for (int i = 0; i < 10; i++) begin
         push(2'(i), 16'(16'hA000 + i), 1);
         chk("stream_valid", bus.OUT_Valid, 1);
         chk("stream_count", bus.OUT_Count, 1);
      end
      step();
      bus.OUT_Ready = 0;
      chk("stream_done", bus.OUT_Valid, 0);
      chk("stream_sb_empty", sb.size(), 0);
      push(SRC_ARITH, 16'h0101, 1);
      push(SRC_LOGIC, 16'h0202, 1);
      push(SRC_CMP,   16'h0303, 1);
      chk("pre_rst_count", bus.OUT_Count, 3);
      #2 RST = 0;
      #1;
      chk("async_valid", bus.OUT_Valid, 0);
      chk("async_data", bus.OUT_Data, 0);
      chk("async_src", bus.OUT_Src, 0);
      chk("async_count", bus.OUT_Count, 0);
      sb.delete();
      #2 RST = 1;
      @(posedge CLK);
      #1;
      chk("post_rst_count", bus.OUT_Count, 0);
      push(SRC_LOGIC, 16'hBEEF, 1);
      chk("post_rst_data", bus.OUT_Data, 16'hBEEF);
      bus.OUT_Ready = 1;
      step();
      bus.OUT_Ready = 0;
      chk("post_rst_sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Output stage of the signed ALU: consumes the registered results and completion flags of the arithmetic, logic, compare and shift units and merges them into one tagged result stream. Each completed result is buffered with a 2-bit source tag in a small FIFO. The FIFO drains to the downstream consumer over a valid/ready handshake. Sticky error flags record dropped results and multi-unit collisions.

## Interface
- OUT_DATA_WIDTH, 16, width of every unit result and of OUT_Data
- DEPTH, 4, FIFO entries; power of 2, ≥2
- CNT_WIDTH, $clog2(DEPTH+1), width of OUT_Count
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-low reset (one clock; reset asynchronous active-low)
- Arith_OUT / Logic_OUT / CMP_OUT / Shift_OUT  in  OUT_DATA_WIDTH each  registered unit results
- Arith_Flag / Logic_Flag / CMP_Flag / Shift_Flag  in  1 each  result-valid flag of each unit, one-cycle qualifier
- OUT_Ready  in  1  consumer accepts head entry
- Err_Clear  in  1  synchronous clear of sticky error flags
- OUT_Data  out  OUT_DATA_WIDTH  head-entry result; 0 when empty
- OUT_Src  out  2  head-entry source tag; 0 when empty
- OUT_Valid  out  1  FIFO non-empty
- OUT_Count  out  CNT_WIDTH  current occupancy
- Full  out  1  occupancy == DEPTH
- Overflow  out  1  sticky: a result was dropped
- Collision  out  1  sticky: more than one flag was high in the same cycle

## Operation
- Push request: any unit flag high. Selected source by fixed priority Arith > Logic > CMP > Shift. Tags: Arith=00, Logic=01, CMP=10, Shift=11.
- ≥2 flags high: push only the highest-priority unit; set Collision; the others are discarded.
- Push accepted if !Full, or if Full and a pop occurs in the same cycle. Otherwise the result is dropped and Overflow is set. Contents and count are unchanged.
- Pop: OUT_Valid && OUT_Ready at a rising edge; rd_ptr advances.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Push on an empty FIFO with OUT_Ready high: the entry is written. No pop happens that cycle because OUT_Valid was low.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is held separately, range 0..DEPTH.
- Err_Clear clears Overflow and Collision. If a set condition and Err_Clear occur in the same cycle, set wins.
- Storage entries are {tag, data}, OUT_DATA_WIDTH+2 bits. Storage is not reset.

## Timing
- Reset values: OUT_Data=0, OUT_Src=0, OUT_Valid=0, OUT_Count=0, Full=0, Overflow=0, Collision=0. Pointers are 0.
- Reset asserted mid-operation: all buffered entries are discarded immediately (asynchronous). Outputs return to reset values without waiting for a clock edge.
- Latency: unit flag high during cycle N → entry written at the edge ending N. It is visible on OUT_Data/OUT_Src with OUT_Valid=1 in cycle N+1.
- First-word fall-through: OUT_Data/OUT_Src/OUT_Valid/Full/OUT_Count are combinational decodes of registered pointers, count and storage only. There is no combinational path from any input to any output.
- OUT_Valid stays high until the pop edge. OUT_Data is stable while OUT_Valid && !OUT_Ready.
- Full-throughput: one push and one pop per cycle is sustained indefinitely at any occupancy ≥1.

## Structure
- Shared package alu_pkg:
  - source-tag constants SRC_ARITH=2'b00, SRC_LOGIC=2'b01, SRC_CMP=2'b10, SRC_SHIFT=2'b11
  - typedef for the {tag, data} entry
  - The same tag constants are reused by the ALU decoder.
- One sub-module, alu_result_fifo: a generic synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/count, and FWFT read.
- The top level holds:
  - the priority select
  - the collision/overflow logic
  - the output zero-gating

## Test plan
- After reset, Shift_Flag=1 with Shift_OUT=16'h00F0 for one cycle, OUT_Ready=0 → next cycle OUT_Valid=1, OUT_Data=16'h00F0, OUT_Src=2'b11, OUT_Count=1. Then OUT_Ready=1 for one cycle → OUT_Valid=0, OUT_Data=0.
- Arith_Flag and Shift_Flag high together (Arith_OUT=16'h0005, Shift_OUT=16'h0002) → one entry, data 16'h0005, tag 00, Collision=1. Err_Clear pulse → Collision=0.
- 5 consecutive single pushes with OUT_Ready=0, DEPTH=4 → Full=1 after 4 pushes, 5th dropped, Overflow=1. Entries read back in push order.
- With Full=1, push 16'h1234 and OUT_Ready=1 in the same cycle → Overflow stays 0, count stays 4, and 16'h1234 emerges last.
- Stream 10 back-to-back pushes with OUT_Ready=1 → one output per cycle with no gaps, occupancy ≤1. Pointer wrap is exercised.
- 3 entries buffered, RST pulsed low between edges → outputs zero immediately. After release, OUT_Count=0 and a new push reads back correctly.
